// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
// Reader side of the PC register. It samples the current PC, fetches one
// instruction at a time over a req/ack handshake, and queues {pc, inst} pairs
// in a small circular FIFO for the decode stage. pc_ena pulses only when a
// fetch response is actually kept, so the PC register advances in lock-step
// with accepted fetches. A redirect flushes the FIFO and any response that is
// still in flight is dropped.
module inst_fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_ena,
    input  logic        redirect,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Fetch control state
    logic [1:0]       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic             req_q, req_d;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;

    // FIFO state
    logic [31:0]      mem_inst_q [DEPTH];
    logic [31:0]      mem_pc_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] remain_s;
    logic [31:0]      out_inst_q, out_inst_d;
    logic [31:0]      out_pc_q, out_pc_d;

    // Fetch FSM: issue from IDLE only, keep or drop the response in REQ/DROP
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Issue only when there is room and no flush is in progress;
                // the address is word aligned.
                if ((count_q < CNT_FULL) && !redirect) begin
                    addr_d  = pc_in & 32'hFFFF_FFFC;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    // A redirect in the ack cycle kills the response.
                    accept_s = !redirect;
                    state_d  = ST_IDLE;
                end else if (redirect) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                // Wait out the stale response; further redirects change nothing here.
                if (imem_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request line is a registered copy of "in REQ or DROP next cycle"
    always_comb begin
        if ((state_d == ST_REQ) || (state_d == ST_DROP)) begin
            req_d = 1'b1;
        end else begin
            req_d = 1'b0;
        end
    end

    // Kept responses advance the PC and enter the FIFO; nothing during reset
    always_comb begin
        if (accept_s && !rst) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (inst_ready && (count_q != CNT_ZERO)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // FIFO pointers, occupancy and the next registered head value
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        remain_s   = count_q;
        out_inst_d = out_inst_q;
        out_pc_d   = out_pc_q;
        if (redirect) begin
            // Flush wins over any push or pop in the same cycle; head output holds.
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                remain_s = count_q - CNT_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
                remain_s = count_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // The head after this cycle is either an older stored entry or,
            // if the FIFO would otherwise be empty, the word being pushed now.
            if (remain_s != CNT_ZERO) begin
                out_inst_d = mem_inst_q[rd_ptr_d];
                out_pc_d   = mem_pc_q[rd_ptr_d];
            end else if (push_s) begin
                out_inst_d = imem_rdata;
                out_pc_d   = addr_q;
            end else begin
                out_inst_d = out_inst_q;
                out_pc_d   = out_pc_q;
            end
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            out_inst_q <= 32'h0000_0000;
            out_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_inst_q <= out_inst_d;
            out_pc_q   <= out_pc_d;
        end
    end

    // FIFO storage: plain datapath, contents are qualified by count
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_inst_q[wr_ptr_q] <= imem_rdata;
            mem_pc_q[wr_ptr_q]   <= addr_q;
        end
    end

    assign pc_ena     = push_s;
    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = (count_q != CNT_ZERO);
    assign inst_out   = out_inst_q;
    assign inst_pc    = out_pc_q;

endmodule
